reg_file_8x16: RTL and testbench
================================

REG_FILE_8X16 -- requirements
Module: reg_file_8x16

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register data width.
REQ-002 SHALL have parameter NREGS, default 8, register count; fixed at 8 because the write decoder is 3-to-8.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port wr_en, input, 1, write request for the current cycle.
REQ-006 SHALL have port wr_addr, input, 3, destination register index.
REQ-007 SHALL have port wr_data, input, DATA_W, write data.
REQ-008 SHALL have port rd_en, input, 1, read request for both read ports.
REQ-009 SHALL have ports rd_addr_a and rd_addr_b, input, 3 each, source register indices.
REQ-010 SHALL have ports rd_data_a and rd_data_b, output, DATA_W each, registered read data.
REQ-011 SHALL have port rd_valid, output, 1, high for exactly the cycle in which rd_data_a/b hold the result of the previous cycle's rd_en.

Function
REQ-012 SHALL store 8 registers R0..R7 of DATA_W bits.
REQ-013 SHALL write wr_data into R[wr_addr] on the rising edge when wr_en=1, using the one-hot enable from the 3-to-8 decoder gated by wr_en.
REQ-014 SHALL treat R0 as hardwired zero: writes to address 0 are discarded, and reads of address 0 return 0.
REQ-015 SHALL have read latency of exactly 1 cycle: rd_en=1 at edge N loads rd_data_a/b from rd_addr_a/b, and sets rd_valid=1 after edge N.
REQ-016 SHALL hold rd_data_a/b at their previous values and drive rd_valid=0 when rd_en=0.
REQ-017 SHALL allow rd_addr_a equal to rd_addr_b; both ports return the same value.
REQ-018 SHALL accept a simultaneous read and write in one cycle; the read result depends on REQ-024/REQ-025.
REQ-019 SHALL perform at most one write per cycle; there is no write-write conflict.

Reset
REQ-020 SHALL, while rst=0, clear R0..R7, rd_data_a, rd_data_b and rd_valid to 0 immediately, independent of clk.
REQ-021 SHALL ignore wr_en and rd_en while rst=0; a write in flight at reset assertion is lost.
REQ-022 SHALL resume normal operation on the first rising edge of clk after rst deasserts.

Configuration
REQ-023 SHALL use macro REGFILE_BYPASS_EN to control write-to-read forwarding.
REQ-024 SHALL, when REGFILE_BYPASS_EN is defined, return wr_data on a read port if that port reads the same cycle as wr_en=1 and its address equals wr_addr (nonzero).
REQ-025 SHALL, when REGFILE_BYPASS_EN is undefined, return the pre-write (old) register contents in the same-cycle read/write case.

Structure
REQ-026 SHALL take DATA_W default, register count, and the R0-zero index constant from the shared regfile package.
REQ-027 SHALL instantiate exactly one sub-module, dcd3x8, for wr_addr-to-one-hot decode.
REQ-028 SHALL contain no other sub-modules; storage and read muxes are local to this module.

Verification
REQ-029 SHALL cover reset: rst=0 mid-operation -> all outputs 0 at once; after release, reading R1..R7 returns 0x0000.
REQ-030 SHALL cover basic write/read: write R3=0xBEEF, then next cycle rd_en with rd_addr_a=3 -> one cycle later rd_data_a=0xBEEF and rd_valid=1.
REQ-031 SHALL cover R0 protection: write R0=0x1234, then read R0 -> 0x0000.
REQ-032 SHALL cover same-cycle conflict: R5=0x0001, then in one cycle write R5=0x00FF while reading R5 -> 0x00FF with REGFILE_BYPASS_EN, 0x0001 without it.
REQ-033 SHALL cover dual port: R2=0xAAAA and R7=0x5555, read a=2 and b=7 -> 0xAAAA/0x5555; then a=b=7 -> 0x5555 on both.
REQ-034 SHALL cover hold: read R2 (0xAAAA), then rd_en=0 for 3 cycles while writing R2=0x0000 -> rd_data_a stays 0xAAAA and rd_valid=0.

Source files
------------

// File: rtl/reg_file_8x16_pkg.sv
// Shared constants, types and helpers for the 8x16 register file.
// Forwarding behaviour is selected in the top by macro REGFILE_BYPASS_EN.
package reg_file_8x16_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int NREGS_DEF  = 8;
    localparam int ADDR_W     = 3;

    typedef logic [ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t R0_IDX = 3'd0;

    // True when a read port hits the register being written this cycle (R0 never forwards)
    function automatic logic bypass_hit(input reg_addr_t rd_addr,
                                        input reg_addr_t wr_addr,
                                        input logic      wr_en);
        return wr_en && (rd_addr == wr_addr) && (rd_addr != R0_IDX);
    endfunction

endpackage

// File: rtl/reg_file_8x16_dcd3x8.sv
// 3-to-8 one-hot decoder with enable, used for write-port register selection.
module dcd3x8
    import reg_file_8x16_pkg::*;
(
    input  logic      en,
    input  reg_addr_t addr,
    output logic [7:0] onehot
);

    // Decode addr to a single hot bit, all-zero when disabled
    always_comb begin
        onehot = 8'd0;
        if (en) begin
            case (addr)
                3'd0:    onehot = 8'b0000_0001;
                3'd1:    onehot = 8'b0000_0010;
                3'd2:    onehot = 8'b0000_0100;
                3'd3:    onehot = 8'b0000_1000;
                3'd4:    onehot = 8'b0001_0000;
                3'd5:    onehot = 8'b0010_0000;
                3'd6:    onehot = 8'b0100_0000;
                3'd7:    onehot = 8'b1000_0000;
                default: onehot = 8'd0;
            endcase
        end else begin
            onehot = 8'd0;
        end
    end

endmodule

// File: rtl/reg_file_8x16.sv
// 8-entry register file, one write port, two registered read ports, R0 reads as zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching reads.
module reg_file_8x16
    import reg_file_8x16_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREGS  = NREGS_DEF
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [2:0]        rd_addr_a,
    input  logic [2:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid
);

    logic [7:0]        wr_sel_s;
    logic [DATA_W-1:0] regs_r [NREGS];
    logic [DATA_W-1:0] rd_a_s;
    logic [DATA_W-1:0] rd_b_s;

    dcd3x8 u_dcd (
        .en     (wr_en),
        .addr   (wr_addr),
        .onehot (wr_sel_s)
    );

    // Storage: R0 is held at zero, decoder bit 0 is never honoured
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (wr_sel_s[i]) begin
                    regs_r[i] <= wr_data;
                end
            end
        end
    end

    // Read mux for port A, with optional same-cycle forwarding
    always_comb begin
        rd_a_s = '0;
        if (rd_addr_a == R0_IDX) begin
            rd_a_s = '0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (bypass_hit(rd_addr_a, wr_addr, wr_en)) begin
            rd_a_s = wr_data;
        end
`endif
        else begin
            rd_a_s = regs_r[rd_addr_a];
        end
    end

    // Read mux for port B, with optional same-cycle forwarding
    always_comb begin
        rd_b_s = '0;
        if (rd_addr_b == R0_IDX) begin
            rd_b_s = '0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (bypass_hit(rd_addr_b, wr_addr, wr_en)) begin
            rd_b_s = wr_data;
        end
`endif
        else begin
            rd_b_s = regs_r[rd_addr_b];
        end
    end

    // Registered read outputs: load on rd_en, otherwise hold data and drop valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
            rd_valid  <= 1'b0;
        end else if (rd_en) begin
            rd_data_a <= rd_a_s;
            rd_data_b <= rd_b_s;
            rd_valid  <= 1'b1;
        end else begin
            rd_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_file_8x16.sv
// Scoreboard bench for reg_file_8x16: stimulus pushes expected read results, a monitor pops and checks.
module tb_reg_file_8x16;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        bit          v;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = 3'd0;
    logic [15:0] wr_data = 16'd0;
    logic        rd_en = 1'b0;
    logic [2:0]  rd_addr_a = 3'd0;
    logic [2:0]  rd_addr_b = 3'd0;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic        rd_valid;

    int total = 0;
    int bad   = 0;

    exp_t        exp_q[$];
    logic [15:0] model [8];
    logic [15:0] last_a = 16'd0;
    logic [15:0] last_b = 16'd0;

    reg_file_8x16 #(.DATA_W(16), .NREGS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .rd_valid  (rd_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [15:0] ref_read(input logic [2:0] ra, input bit we,
                                             input logic [2:0] wa, input logic [15:0] wd);
        if (ra == 3'd0) return 16'd0;
        if (BYP && we && wa == ra) return wd;
        return model[ra];
    endfunction

    // One clock of stimulus; expected outcome is queued for the monitor
    task automatic step(input bit we, input logic [2:0] wa, input logic [15:0] wd,
                        input bit re, input logic [2:0] ra, input logic [2:0] rb);
        exp_t e;
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_addr_a = ra; rd_addr_b = rb;
        if (re) begin
            last_a = ref_read(ra, we, wa, wd);
            last_b = ref_read(rb, we, wa, wd);
        end
        e.v = re; e.a = last_a; e.b = last_b;
        exp_q.push_back(e);
        if (we && wa != 3'd0) model[wa] = wd;
        @(posedge clk);
        #2;
    endtask

    // Monitor: one expected entry per active clock edge
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rd_valid", {15'd0, rd_valid}, {15'd0, e.v});
            chk("rd_data_a", rd_data_a, e.a);
            chk("rd_data_b", rd_data_b, e.b);
        end else begin
            chk("idle_rd_valid", {15'd0, rd_valid}, 16'd0);
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) model[i] = 16'd0;
        #1;
        chk("reset_data_a", rd_data_a, 16'd0);
        chk("reset_valid", {15'd0, rd_valid}, 16'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;

        // basic write/read
        step(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 3'd0);
        step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 3'd0);
        // R0 protection
        step(1'b1, 3'd0, 16'h1234, 1'b0, 3'd0, 3'd0);
        step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 3'd0);
        // same-cycle conflict
        step(1'b1, 3'd5, 16'h0001, 1'b0, 3'd0, 3'd0);
        step(1'b1, 3'd5, 16'h00FF, 1'b1, 3'd5, 3'd5);
        step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 3'd0);
        // dual port
        step(1'b1, 3'd2, 16'hAAAA, 1'b0, 3'd0, 3'd0);
        step(1'b1, 3'd7, 16'h5555, 1'b0, 3'd0, 3'd0);
        step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd7);
        step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd7, 3'd7);
        // hold while idle and R2 is overwritten
        step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd2);
        for (int i = 0; i < 3; i++) step(1'b1, 3'd2, 16'h0000, 1'b0, 3'd0, 3'd0);
        step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        // reset mid-operation with a write and read in flight
        step(1'b1, 3'd6, 16'hC3C3, 1'b0, 3'd0, 3'd0);
        step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 3'd6);
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'hFFFF;
        rd_en = 1'b1; rd_addr_a = 3'd6; rd_addr_b = 3'd6;
        #1 rst = 1'b0;
        #1;
        chk("async_rst_data_a", rd_data_a, 16'd0);
        chk("async_rst_data_b", rd_data_b, 16'd0);
        chk("async_rst_valid", {15'd0, rd_valid}, 16'd0);
        @(posedge clk); #2;
        wr_en = 1'b0; rd_en = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) model[i] = 16'd0;
        last_a = 16'd0; last_b = 16'd0;
        for (int i = 1; i < 8; i++) step(1'b0, 3'd0, 16'h0000, 1'b1, 3'(i), 3'(8 - i));
        step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0);
        step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0);

        chk("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
